// File: rtl/mem_arbiter_if.sv
// Bundle of CPU, host and data-memory signals seen by mem_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_stall;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [3:0]    host_len;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          host_beat;
  logic          host_done;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic          mem_ren;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  host_req, host_we, host_addr, host_len, host_wdata,
    output host_rdata, host_beat, host_done,
    output mem_addr, mem_wdata, mem_wen, mem_ren,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output host_req, host_we, host_addr, host_len, host_wdata,
    input  host_rdata, host_beat, host_done,
    input  mem_addr, mem_wdata, mem_wen, mem_ren,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data memory between a CPU and a host burst port.
// Define MEM_ARBITER_BURST_EN for multi-beat host bursts; otherwise every host grant is one beat.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CPU, HOST} state_t;

  state_t        state, nxt_state;
  logic          last_grant, nxt_grant;   // 1 = host was granted last
  logic [3:0]    cnt, nxt_cnt;
  logic          lat_we, nxt_we;
  logic [AW-1:0] lat_addr, nxt_addr;
  logic [DW-1:0] lat_wdata, nxt_wdata;
  logic [3:0]    last_beat;
  logic          done, sample, c_req, h_req;

`ifdef MEM_ARBITER_BURST_EN
  logic [3:0] lat_len, nxt_len;
  assign last_beat = lat_len;
`else
  logic [3:0] unused_len;
  assign unused_len = bus.host_len;
  assign last_beat  = 4'd0;
`endif

  assign done   = (state == HOST) && (cnt == last_beat);
  assign sample = (state == IDLE) || (state == CPU) || done;
  // A requester holds req through its completing cycle, so that req is the
  // one being retired and must not win a fresh grant.
  assign c_req  = bus.cpu_req  && (state != CPU);
  assign h_req  = bus.host_req && (state != HOST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
`ifdef MEM_ARBITER_BURST_EN
      lat_len    <= '0;
`endif
    end else begin
      state      <= nxt_state;
      last_grant <= nxt_grant;
      cnt        <= nxt_cnt;
      lat_we     <= nxt_we;
      lat_addr   <= nxt_addr;
      lat_wdata  <= nxt_wdata;
`ifdef MEM_ARBITER_BURST_EN
      lat_len    <= nxt_len;
`endif
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_grant = last_grant;
    nxt_cnt   = cnt;
    nxt_we    = lat_we;
    nxt_addr  = lat_addr;
    nxt_wdata = lat_wdata;
`ifdef MEM_ARBITER_BURST_EN
    nxt_len   = lat_len;
`endif
    if (state == HOST && !done) nxt_cnt = cnt + 4'd1;
    if (sample) begin
      nxt_cnt = '0;
      if (c_req && (!h_req || last_grant)) begin
        nxt_state = CPU;
        nxt_grant = 1'b0;
        nxt_we    = bus.cpu_we;
        nxt_addr  = bus.cpu_addr;
        nxt_wdata = bus.cpu_wdata;
      end else if (h_req) begin
        nxt_state = HOST;
        nxt_grant = 1'b1;
        nxt_we    = bus.host_we;
        nxt_addr  = bus.host_addr;
`ifdef MEM_ARBITER_BURST_EN
        nxt_len   = bus.host_len;
`endif
      end else begin
        nxt_state = IDLE;
      end
    end
  end

  always_comb begin
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_wen    = 1'b0;
    bus.mem_ren    = 1'b0;
    bus.cpu_ack    = 1'b0;
    bus.cpu_rdata  = '0;
    bus.host_beat  = 1'b0;
    bus.host_done  = 1'b0;
    bus.host_rdata = '0;
    unique case (state)
      CPU: begin
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
        bus.mem_wen   = lat_we;
        bus.mem_ren   = !lat_we;
        bus.cpu_ack   = 1'b1;
        bus.cpu_rdata = bus.mem_rdata;
      end
      HOST: begin
        bus.mem_addr   = lat_addr + AW'(cnt);
        bus.mem_wdata  = bus.host_wdata;
        bus.mem_wen    = lat_we;
        bus.mem_ren    = !lat_we;
        bus.host_beat  = 1'b1;
        bus.host_done  = done;
        bus.host_rdata = bus.mem_rdata;
      end
      default: ;
    endcase
    // Gated by reset so every output reads 0 while reset is held.
    bus.cpu_stall = rst_n && bus.cpu_req && (state != CPU);
  end

endmodule
